// File: rtl/bidir_bus_arbiter.sv
// Ownership arbiter for a shared half-duplex line: drives the A->B / B->A buffer enables,
// inserts turnaround cycles on direction change, and caps bursts while the other side waits.
module bidir_bus_arbiter #(
    parameter int unsigned TURN_CYC  = 2,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic       req_b,
    output logic       en_ab,
    output logic       en_ba,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       turn,
    output logic [7:0] beat_cnt
);

    localparam int unsigned TCW = 4;
    localparam int unsigned BW  = 8;
    localparam logic [TCW-1:0] TURN_LAST  = TCW'(TURN_CYC - 1);
    localparam logic [BW-1:0]  BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic DIR_A = 1'b0;
    localparam logic DIR_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TURN,
        ST_OWN_A,
        ST_OWN_B
    } state_t;

    state_t         r_state;
    logic           r_target;
    logic [TCW-1:0] r_tcnt;
    logic [BW-1:0]  r_beat;
    logic           r_last_vld;
    logic           r_last_dir;
    logic           r_gnt_a;
    logic           r_gnt_b;
    logic           r_turn;

    state_t         w_state_nxt;
    logic           w_target_nxt;
    logic [TCW-1:0] w_tcnt_nxt;
    logic [BW-1:0]  w_beat_nxt;
    logic           w_last_vld_nxt;
    logic           w_last_dir_nxt;

    logic w_win;
    logic w_own_dir;
    logic w_own_req;
    logic w_oth_req;
    logic w_tgt_req;

    function automatic state_t own_state(input logic dir);
        return (dir == DIR_B) ? ST_OWN_B : ST_OWN_A;
    endfunction

    // Contested idle goes to whoever did not own last; with no history A wins.
    assign w_win     = (req_a && req_b) ? (r_last_vld && (r_last_dir == DIR_A)) : req_b;
    assign w_own_dir = (r_state == ST_OWN_B);
    assign w_own_req = w_own_dir ? req_b : req_a;
    assign w_oth_req = w_own_dir ? req_a : req_b;
    assign w_tgt_req = (r_target == DIR_B) ? req_b : req_a;

    always_comb begin
        w_state_nxt    = r_state;
        w_target_nxt   = r_target;
        w_tcnt_nxt     = r_tcnt;
        w_beat_nxt     = '0;
        w_last_vld_nxt = r_last_vld;
        w_last_dir_nxt = r_last_dir;

        case (r_state)
            ST_IDLE: begin
                if (req_a || req_b) begin
                    if (!r_last_vld || (w_win == r_last_dir)) begin
                        w_state_nxt    = own_state(w_win);
                        w_last_vld_nxt = 1'b1;
                        w_last_dir_nxt = w_win;
                    end else begin
                        w_state_nxt  = ST_TURN;
                        w_target_nxt = w_win;
                        w_tcnt_nxt   = '0;
                    end
                end
            end
            ST_TURN: begin
                // Line is conditioned for the target once turnaround ends, granted or not.
                if (r_tcnt == TURN_LAST) begin
                    w_last_vld_nxt = 1'b1;
                    w_last_dir_nxt = r_target;
                    w_state_nxt    = w_tgt_req ? own_state(r_target) : ST_IDLE;
                end else begin
                    w_tcnt_nxt = r_tcnt + TCW'(1);
                end
            end
            ST_OWN_A, ST_OWN_B: begin
                if (!w_own_req || (r_beat == BURST_LAST)) begin
                    if (w_oth_req) begin
                        w_state_nxt  = ST_TURN;
                        w_target_nxt = ~w_own_dir;
                        w_tcnt_nxt   = '0;
                    end else if (!w_own_req) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (r_beat != '1) begin
                    w_beat_nxt = r_beat + BW'(1);
                end else begin
                    w_beat_nxt = r_beat;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register with outputs registered from the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_target   <= DIR_A;
            r_tcnt     <= '0;
            r_beat     <= '0;
            r_last_vld <= 1'b0;
            r_last_dir <= DIR_A;
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b0;
            r_turn     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_target   <= w_target_nxt;
            r_tcnt     <= w_tcnt_nxt;
            r_beat     <= w_beat_nxt;
            r_last_vld <= w_last_vld_nxt;
            r_last_dir <= w_last_dir_nxt;
            r_gnt_a    <= (w_state_nxt == ST_OWN_A);
            r_gnt_b    <= (w_state_nxt == ST_OWN_B);
            r_turn     <= (w_state_nxt == ST_TURN);
        end
    end

    assign en_ab    = r_gnt_a;
    assign gnt_a    = r_gnt_a;
    assign en_ba    = r_gnt_b;
    assign gnt_b    = r_gnt_b;
    assign turn     = r_turn;
    assign beat_cnt = r_beat;

endmodule

// File: tb/tb_bidir_bus_arbiter.sv
// Bench for bidir_bus_arbiter (TURN_CYC=2, MAX_BURST=8): hand-derived per-cycle expectations
// pass through a scoreboard queue; async reset is checked off-edge.
module tb_bidir_bus_arbiter;

    localparam logic [2:0] O_IDLE = 3'b000;
    localparam logic [2:0] O_A    = 3'b100;
    localparam logic [2:0] O_B    = 3'b010;
    localparam logic [2:0] O_T    = 3'b001;

    typedef struct {
        logic       ra;
        logic       rb;
        logic [2:0] own;
        logic [7:0] beat;
    } vec_t;

    typedef struct {
        string       tag;
        logic [12:0] val;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       req_a;
    logic       req_b;
    logic       en_ab;
    logic       en_ba;
    logic       gnt_a;
    logic       gnt_b;
    logic       turn;
    logic [7:0] beat_cnt;

    int   n_checks;
    int   n_errors;
    exp_t sb[$];
    vec_t tbl[9];

    bidir_bus_arbiter #(
        .TURN_CYC (2),
        .MAX_BURST(8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_a   (req_a),
        .req_b   (req_b),
        .en_ab   (en_ab),
        .en_ba   (en_ba),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .turn    (turn),
        .beat_cnt(beat_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [12:0] actual();
        return {en_ab, gnt_a, en_ba, gnt_b, turn, beat_cnt};
    endfunction

    task automatic check(input string tag, input logic [12:0] act, input logic [12:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual {en_ab,gnt_a,en_ba,gnt_b,turn}=%b beat=%0d, required %b beat=%0d",
                     tag, act[12:8], act[7:0], exp[12:8], exp[7:0]);
        end
    endtask

    // Called in the negedge phase: drive, queue the expectation, compare after the edge.
    task automatic apply(input logic ra, input logic rb, input logic [2:0] own,
                         input logic [7:0] beat, input string tag);
        exp_t e;
        req_a = ra;
        req_b = rb;
        e.tag = tag;
        e.val = {own[2], own[2], own[1], own[1], own[0], beat};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check(e.tag, actual(), e.val);
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        req_a    = 1'b0;
        req_b    = 1'b0;

        tbl[0] = '{1'b0, 1'b0, O_IDLE, 8'd0};
        tbl[1] = '{1'b1, 1'b0, O_A,    8'd0};
        tbl[2] = '{1'b1, 1'b0, O_A,    8'd1};
        tbl[3] = '{1'b1, 1'b0, O_A,    8'd2};
        tbl[4] = '{1'b0, 1'b0, O_IDLE, 8'd0};
        tbl[5] = '{1'b0, 1'b1, O_T,    8'd0};
        tbl[6] = '{1'b0, 1'b1, O_T,    8'd0};
        tbl[7] = '{1'b0, 1'b1, O_B,    8'd0};
        tbl[8] = '{1'b0, 1'b1, O_B,    8'd1};

        @(posedge clk);
        #1;
        check("reset_state", actual(), 13'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // A alone (no turnaround), drop, then B alone (two turn cycles)
        for (int i = 0; i < 9; i++) begin
            apply(tbl[i].ra, tbl[i].rb, tbl[i].own, tbl[i].beat, $sformatf("vec%0d", i));
        end

        // Both held: B finishes its burst, then A8/T2/B8/T2 repeats
        for (int k = 2; k < 8; k++) begin
            apply(1'b1, 1'b1, O_B, 8'(k), $sformatf("both_b0_%0d", k));
        end
        for (int r = 0; r < 2; r++) begin
            apply(1'b1, 1'b1, O_T, 8'd0, $sformatf("both_t_ba_%0d", r));
            apply(1'b1, 1'b1, O_T, 8'd0, $sformatf("both_t_ba_%0d", r));
            for (int k = 0; k < 8; k++) begin
                apply(1'b1, 1'b1, O_A, 8'(k), $sformatf("both_a%0d_%0d", r, k));
            end
            apply(1'b1, 1'b1, O_T, 8'd0, $sformatf("both_t_ab_%0d", r));
            apply(1'b1, 1'b1, O_T, 8'd0, $sformatf("both_t_ab_%0d", r));
            for (int k = 0; k < 8; k++) begin
                apply(1'b1, 1'b1, O_B, 8'(k), $sformatf("both_b%0d_%0d", r, k));
            end
        end

        // B drops while A waits; A then holds alone and wraps without turnaround
        apply(1'b1, 1'b0, O_T, 8'd0, "a_alone_t0");
        apply(1'b1, 1'b0, O_T, 8'd0, "a_alone_t1");
        for (int k = 0; k < 20; k++) begin
            apply(1'b1, 1'b0, O_A, 8'(k % 8), $sformatf("a_alone_%0d", k));
        end

        // Abandoned turnaround toward B
        apply(1'b1, 1'b1, O_A,    8'd4, "abn_a4");
        apply(1'b0, 1'b1, O_T,    8'd0, "abn_t0");
        apply(1'b0, 1'b0, O_T,    8'd0, "abn_t1");
        apply(1'b0, 1'b0, O_IDLE, 8'd0, "abn_idle0");
        apply(1'b0, 1'b0, O_IDLE, 8'd0, "abn_idle1");
        apply(1'b0, 1'b1, O_B,    8'd0, "abn_b_fast");
        apply(1'b0, 1'b1, O_B,    8'd1, "abn_b1");
        apply(1'b0, 1'b0, O_IDLE, 8'd0, "abn_b_drop");

        // Contested idle with last_dir=B: A wins but needs a turnaround
        apply(1'b1, 1'b1, O_T,    8'd0, "idle_both_t0");
        apply(1'b1, 1'b1, O_T,    8'd0, "idle_both_t1");
        apply(1'b1, 1'b1, O_A,    8'd0, "idle_both_a0");
        apply(1'b0, 1'b0, O_IDLE, 8'd0, "idle_both_drop");

        // Async reset in the middle of B ownership
        apply(1'b0, 1'b1, O_T, 8'd0, "rst_b_t0");
        apply(1'b0, 1'b1, O_T, 8'd0, "rst_b_t1");
        apply(1'b0, 1'b1, O_B, 8'd0, "rst_b_b0");
        apply(1'b0, 1'b1, O_B, 8'd1, "rst_b_b1");
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_own_b", actual(), 13'd0);
        req_a = 1'b1;
        req_b = 1'b1;
        @(posedge clk);
        #1;
        check("rst_hold_own_b", actual(), 13'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 1'b1, O_A, 8'd0, "rst_rel1_a0");
        apply(1'b1, 1'b1, O_A, 8'd1, "rst_rel1_a1");

        // Async reset in the middle of a turnaround
        apply(1'b0, 1'b1, O_T, 8'd0, "rst_t_t0");
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_turn", actual(), 13'd0);
        req_a = 1'b1;
        req_b = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 1'b1, O_A,    8'd0, "rst_rel2_a0");
        apply(1'b0, 1'b0, O_IDLE, 8'd0, "rst_rel2_idle");

        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: actual %0d entries left, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
